// File: rtl/audio_adc_unpacker.sv
// audio_adc_unpacker: pops packed stereo words from the audio ADC FIFO
// (1-cycle read latency), splits them into signed left/right samples and
// presents them on a valid/ready stream with a running transfer count.
// Optional per-channel peak-hold meters: define AUDIO_ADC_UNPACKER_PEAK_EN.
module audio_adc_unpacker #(
  parameter  int DATA_WIDTH   = 32,
  localparam int SAMPLE_WIDTH = DATA_WIDTH / 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    fifo_empty,
  output logic                    fifo_read,
  input  logic [DATA_WIDTH-1:0]   fifo_readdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_WIDTH-1:0] out_left,
  output logic [SAMPLE_WIDTH-1:0] out_right,
  output logic [31:0]             sample_count,
  input  logic                    peak_clear,
  output logic [SAMPLE_WIDTH-2:0] peak_left,
  output logic [SAMPLE_WIDTH-2:0] peak_right
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    fifo_read_q, fifo_read_d;
  logic                    out_valid_q, out_valid_d;
  logic [SAMPLE_WIDTH-1:0] out_left_q, out_left_d;
  logic [SAMPLE_WIDTH-1:0] out_right_q, out_right_d;
  logic [31:0]             sample_count_q, sample_count_d;

  logic transfer;
  logic slot_free;

  assign transfer  = out_valid_q & out_ready;
  // The slot is usable if empty now or being drained on this edge; since a
  // pop takes two more cycles to land, CAPTURE always finds it empty.
  assign slot_free = ~out_valid_q | out_ready;

  // Next-state logic; fifo_read is registered so it is high exactly in FETCH
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && !fifo_empty && slot_free) state_d = FETCH;
      FETCH:   state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fifo_read_d = (state_d == FETCH);
  end

  // Output slot and transfer counter
  always_comb begin
    out_valid_d    = out_valid_q;
    out_left_d     = out_left_q;
    out_right_d    = out_right_q;
    sample_count_d = sample_count_q;
    if (transfer) begin
      out_valid_d    = 1'b0;
      sample_count_d = sample_count_q + 32'd1;
    end
    // Read data is valid in the cycle after the pop, which is CAPTURE
    if (state_q == CAPTURE) begin
      out_valid_d = 1'b1;
      out_left_d  = fifo_readdata[DATA_WIDTH-1:SAMPLE_WIDTH];
      out_right_d = fifo_readdata[SAMPLE_WIDTH-1:0];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      fifo_read_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      out_left_q     <= '0;
      out_right_q    <= '0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      fifo_read_q    <= fifo_read_d;
      out_valid_q    <= out_valid_d;
      out_left_q     <= out_left_d;
      out_right_q    <= out_right_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign fifo_read    = fifo_read_q;
  assign out_valid    = out_valid_q;
  assign out_left     = out_left_q;
  assign out_right    = out_right_q;
  assign sample_count = sample_count_q;

`ifdef AUDIO_ADC_UNPACKER_PEAK_EN
  logic [SAMPLE_WIDTH-2:0] peak_left_q, peak_left_d;
  logic [SAMPLE_WIDTH-2:0] peak_right_q, peak_right_d;
  logic [SAMPLE_WIDTH-2:0] mag_left, mag_right;

  // |s| in SAMPLE_WIDTH-1 bits; the most negative code saturates to all ones
  function automatic logic [SAMPLE_WIDTH-2:0] magnitude(input logic [SAMPLE_WIDTH-1:0] s);
    logic [SAMPLE_WIDTH-1:0] neg;
    neg = -s;
    if (!s[SAMPLE_WIDTH-1])     return s[SAMPLE_WIDTH-2:0];
    else if (neg[SAMPLE_WIDTH-1]) return '1;
    else                        return neg[SAMPLE_WIDTH-2:0];
  endfunction

  assign mag_left  = magnitude(out_left_q);
  assign mag_right = magnitude(out_right_q);

  // Peak hold: a clear coinciding with a transfer restarts from that sample
  always_comb begin
    peak_left_d  = peak_left_q;
    peak_right_d = peak_right_q;
    if (transfer) begin
      if (peak_clear || mag_left  > peak_left_q)  peak_left_d  = mag_left;
      if (peak_clear || mag_right > peak_right_q) peak_right_d = mag_right;
    end else if (peak_clear) begin
      peak_left_d  = '0;
      peak_right_d = '0;
    end
  end

  // Peak registers
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_left_q  <= '0;
      peak_right_q <= '0;
    end else begin
      peak_left_q  <= peak_left_d;
      peak_right_q <= peak_right_d;
    end
  end

  assign peak_left  = peak_left_q;
  assign peak_right = peak_right_q;
`else
  logic unused_peak_clear;
  assign unused_peak_clear = peak_clear;
  assign peak_left         = '0;
  assign peak_right        = '0;
`endif

endmodule

// File: tb/tb_audio_adc_unpacker.sv
// Directed self-checking bench for audio_adc_unpacker with a behavioural
// 1-cycle-latency FIFO model on the read side.
module tb_audio_adc_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_read;
  logic [31:0] fifo_readdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic [31:0] sample_count;
  logic        peak_clear;
  logic [14:0] peak_left;
  logic [14:0] peak_right;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  audio_adc_unpacker dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .fifo_readdata (fifo_readdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_left      (out_left),
    .out_right     (out_right),
    .sample_count  (sample_count),
    .peak_clear    (peak_clear),
    .peak_left     (peak_left),
    .peak_right    (peak_right)
  );

  // FIFO model: writer pointer owned by the stimulus thread, reader by this block
  logic [31:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_count = 0;
  int underflow = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_read) begin
      pop_count <= pop_count + 1;
      if (wr_ptr == rd_ptr) begin
        underflow <= underflow + 1;
      end else begin
        fifo_readdata <= fifo_mem[rd_ptr % 64];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Waits (bounded) for an accepted pair; returns at the negedge after it
  task automatic wait_xfer(output logic [15:0] l, output logic [15:0] r, output bit ok);
    ok = 1'b0;
    l  = '0;
    r  = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (out_valid && out_ready) begin
        l  = out_left;
        r  = out_right;
        ok = 1'b1;
        $display("xfer L=%h R=%h count_before=%0d", l, r, sample_count);
      end
      tick();
    end
  endtask

  // Waits (bounded) until fifo_read is seen high; stays at that negedge
  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (fifo_read) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    enable     = 1'b0;
    out_ready  = 1'b0;
    peak_clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    enable     = 1'b1;
    out_ready  = 1'b0;
    peak_clear = 1'b0;
    tick();
    tick();
    total++; if (fifo_read !== 1'b0)     begin bad++; $display("FAIL rst_fifo_read: got %b want 0", fifo_read); end
    total++; if (out_valid !== 1'b0)     begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_left !== 16'h0)     begin bad++; $display("FAIL rst_out_left: got %h want 0", out_left); end
    total++; if (out_right !== 16'h0)    begin bad++; $display("FAIL rst_out_right: got %h want 0", out_right); end
    total++; if (sample_count !== 32'h0) begin bad++; $display("FAIL rst_count: got %h want 0", sample_count); end
    total++; if (peak_left !== 15'h0 || peak_right !== 15'h0) begin bad++; $display("FAIL rst_peaks: got %h/%h want 0/0", peak_left, peak_right); end
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    total++; if (fifo_read !== 1'b0) begin bad++; $display("FAIL idle_no_read: got %b want 0", fifo_read); end
  endtask

  task automatic test_pop_split();
    int base;
    do_reset();
    base      = pop_count;
    enable    = 1'b1;
    out_ready = 1'b1;
    push(32'h1234_ABCD);
    tick();
    total++; if (fifo_read !== 1'b1) begin bad++; $display("FAIL split_read_hi: got %b want 1", fifo_read); end
    tick();
    total++; if (fifo_read !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL split_capture: got read=%b valid=%b want 0/0", fifo_read, out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL split_valid: got %b want 1", out_valid); end
    total++; if (out_left !== 16'h1234 || out_right !== 16'hABCD) begin bad++; $display("FAIL split_data: got %h/%h want 1234/abcd", out_left, out_right); end
    total++; if (sample_count !== 32'd0) begin bad++; $display("FAIL split_count0: got %0d want 0", sample_count); end
    $display("xfer L=%h R=%h count_before=%0d", out_left, out_right, sample_count);
    tick();
    total++; if (sample_count !== 32'd1 || out_valid !== 1'b0) begin bad++; $display("FAIL split_after: got count=%0d valid=%b want 1/0", sample_count, out_valid); end
    total++; if (pop_count - base !== 1) begin bad++; $display("FAIL split_pops: got %0d want 1", pop_count - base); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [3];
    logic [15:0] l, r;
    bit ok;
    int base;
    exp_w[0] = 32'h0001_0002;
    exp_w[1] = 32'hFFFF_8000;
    exp_w[2] = 32'h7FFF_0001;
    do_reset();
    base      = pop_count;
    enable    = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(exp_w[k]);
    repeat (12) tick();
    total++; if (pop_count - base !== 1) begin bad++; $display("FAIL bp_single_pop: got %0d want 1", pop_count - base); end
    total++; if (out_valid !== 1'b1 || out_left !== 16'h0001 || out_right !== 16'h0002) begin bad++; $display("FAIL bp_hold: got v=%b %h/%h want 1 0001/0002", out_valid, out_left, out_right); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_xfer(l, r, ok);
      total++; if (!ok || {l, r} !== exp_w[k]) begin bad++; $display("FAIL bp_word%0d: got %h%h ok=%b want %h", k, l, r, ok, exp_w[k]); end
    end
    total++; if (sample_count !== 32'd3 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_final: got count=%0d valid=%b want 3/0", sample_count, out_valid); end
  endtask

  task automatic test_empty_enable();
    logic [15:0] l, r;
    bit ok;
    int base;
    int reads;
    do_reset();
    base      = pop_count;
    reads     = 0;
    enable    = 1'b1;
    out_ready = 1'b1;
    repeat (20) begin
      if (fifo_read) reads++;
      tick();
    end
    total++; if (reads !== 0 || out_valid !== 1'b0) begin bad++; $display("FAIL empty_no_read: got reads=%0d valid=%b want 0/0", reads, out_valid); end
    push(32'h1111_2222);
    push(32'h3333_4444);
    wait_read(ok);
    total++; if (!ok) begin bad++; $display("FAIL en_read_seen: got timeout want fifo_read"); end
    enable = 1'b0;
    wait_xfer(l, r, ok);
    total++; if (!ok || l !== 16'h1111 || r !== 16'h2222) begin bad++; $display("FAIL en_inflight: got %h/%h ok=%b want 1111/2222", l, r, ok); end
    repeat (10) tick();
    total++; if (pop_count - base !== 1 || out_valid !== 1'b0) begin bad++; $display("FAIL en_stopped: got pops=%0d valid=%b want 1/0", pop_count - base, out_valid); end
    enable = 1'b1;
    wait_xfer(l, r, ok);
    total++; if (!ok || l !== 16'h3333 || r !== 16'h4444) begin bad++; $display("FAIL en_resume: got %h/%h ok=%b want 3333/4444", l, r, ok); end
    total++; if (pop_count - base !== 2 || underflow !== 0) begin bad++; $display("FAIL en_pops: got pops=%0d underflow=%0d want 2/0", pop_count - base, underflow); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] l, r;
    bit ok;
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    push(32'hAAAA_0001);
    wait_xfer(l, r, ok);
    total++; if (!ok || sample_count !== 32'd1) begin bad++; $display("FAIL rm_pre: got count=%0d ok=%b want 1", sample_count, ok); end
    out_ready = 1'b0;
    push(32'h5555_AAAA);
    wait_read(ok);
    tick();
    reset = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || out_left !== 16'h0 || out_right !== 16'h0) begin bad++; $display("FAIL rm_outputs: got v=%b %h/%h want 0 0000/0000", out_valid, out_left, out_right); end
    total++; if (sample_count !== 32'd0 || fifo_read !== 1'b0) begin bad++; $display("FAIL rm_count: got count=%0d read=%b want 0/0", sample_count, fifo_read); end
    reset = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_discard: got valid=%b want 0", out_valid); end
    out_ready = 1'b1;
    push(32'h1357_2468);
    wait_xfer(l, r, ok);
    total++; if (!ok || l !== 16'h1357 || r !== 16'h2468) begin bad++; $display("FAIL rm_resume: got %h/%h ok=%b want 1357/2468", l, r, ok); end
    total++; if (sample_count !== 32'd1) begin bad++; $display("FAIL rm_count_after: got %0d want 1", sample_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b0;
    push(32'hC0DE_0042);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %b want 1", out_valid); end
    force dut.sample_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.sample_count_q;
    out_ready = 1'b1;
    tick();
    $display("xfer L=%h R=%h count_after=%0d", out_left, out_right, sample_count);
    total++; if (sample_count !== 32'h0 || out_valid !== 1'b0) begin bad++; $display("FAIL wrap_count: got %h valid=%b want 00000000/0", sample_count, out_valid); end
  endtask

`ifdef AUDIO_ADC_UNPACKER_PEAK_EN
  task automatic test_peak();
    logic [15:0] l, r;
    bit ok;
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    push(32'h8000_0064);
    push(32'h0005_FF38);
    wait_xfer(l, r, ok);
    total++; if (!ok || peak_left !== 15'd32767 || peak_right !== 15'd100) begin bad++; $display("FAIL peak_first: got %0d/%0d want 32767/100", peak_left, peak_right); end
    wait_xfer(l, r, ok);
    total++; if (!ok || peak_left !== 15'd32767 || peak_right !== 15'd200) begin bad++; $display("FAIL peak_second: got %0d/%0d want 32767/200", peak_left, peak_right); end
    push(32'h0007_FFFD);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    peak_clear = 1'b1;
    $display("xfer L=%h R=%h with peak_clear", out_left, out_right);
    tick();
    peak_clear = 1'b0;
    total++; if (peak_left !== 15'd7 || peak_right !== 15'd3) begin bad++; $display("FAIL peak_clear_xfer: got %0d/%0d want 7/3", peak_left, peak_right); end
    peak_clear = 1'b1;
    tick();
    peak_clear = 1'b0;
    total++; if (peak_left !== 15'd0 || peak_right !== 15'd0) begin bad++; $display("FAIL peak_clear: got %0d/%0d want 0/0", peak_left, peak_right); end
  endtask
`else
  task automatic test_peak();
    logic [15:0] l, r;
    bit ok;
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    push(32'h8000_8000);
    wait_xfer(l, r, ok);
    total++; if (!ok || peak_left !== 15'd0 || peak_right !== 15'd0) begin bad++; $display("FAIL peak_off: got %0d/%0d ok=%b want 0/0", peak_left, peak_right, ok); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    out_ready  = 1'b0;
    peak_clear = 1'b0;
    tick();
    test_reset();
    test_pop_split();
    test_backpressure();
    test_empty_enable();
    test_reset_mid();
    test_wrap();
    test_peak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
